weight_update_seq: RTL and testbench

- Sequencer that time-shares one mu·e·x weight-update datapath across all NTAPS weights of a filter stage.
- On a start pulse it latches mu_error and walks tap indices 0..NTAPS-1.
- For each tap it reads the x tap and the weight from external storage, forms the rounded product, and adds it to the weight through a one-cycle retiming register. It then writes the new weight back.
- It sits between the error/step-size computation and the weight register file of the adaptive filter.

---
 rtl/weight_update_seq.sv | 108 ++++++++++
 tb/tb_weight_update_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_update_seq.sv
// Time-shared mu*e*x weight-update sequencer.
// Walks all taps once per start with a one-cycle retiming stage.
module weight_update_seq #(
  parameter int WIDTH = 16,
  parameter int QP    = 12,
  parameter int NTAPS = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] mu_error,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    x_rd_addr,
  input  logic [WIDTH-1:0] x_rd_data,
  output logic [AW-1:0]    w_rd_addr,
  input  logic [WIDTH-1:0] w_rd_data,
  output logic             w_wr_en,
  output logic [AW-1:0]    w_wr_addr,
  output logic [WIDTH-1:0] w_wr_data
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);
  localparam logic [2*WIDTH-1:0] HALF =
    {{(2*WIDTH-1){1'b0}}, 1'b1} << (QP - 1);

  state_t state_q, state_d;

  logic [AW-1:0]    k_q;
  logic [WIDTH-1:0] mu_q;
  logic [WIDTH-1:0] term_q;
  logic [WIDTH-1:0] w_q;
  logic [AW-1:0]    kd_q;
  logic             wr_q;

  logic                    last;
  logic signed [2*WIDTH-1:0] x_ext;
  logic signed [2*WIDTH-1:0] mu_ext;
  logic signed [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0]      prod_rnd;
  logic [WIDTH-1:0]        term;

  assign last = (k_q == LAST);

  // Rounded fixed-point product for the tap being read.
  assign x_ext    = {{WIDTH{x_rd_data[WIDTH-1]}}, x_rd_data};
  assign mu_ext   = {{WIDTH{mu_q[WIDTH-1]}}, mu_q};
  assign prod     = x_ext * mu_ext;
  assign prod_rnd = $unsigned(prod) + HALF;
  assign term     = WIDTH'(prod_rnd >> QP);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: one RUN cycle per tap, then a drain write.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Tap index, latched step term and retiming stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      k_q    <= '0;
      mu_q   <= '0;
      term_q <= '0;
      w_q    <= '0;
      kd_q   <= '0;
      wr_q   <= 1'b0;
    end else begin
      wr_q <= (state_q == RUN);
      if (state_q == IDLE && start) begin
        mu_q <= mu_error;
        k_q  <= '0;
      end
      if (state_q == RUN) begin
        term_q <= term;
        w_q    <= w_rd_data;
        kd_q   <= k_q;
        if (!last) k_q <= k_q + AW'(1);
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DRAIN);
  assign x_rd_addr = k_q;
  assign w_rd_addr = k_q;
  assign w_wr_en   = wr_q;
  assign w_wr_addr = kd_q;
  assign w_wr_data = w_q + term_q;

endmodule

// File: tb/tb_weight_update_seq.sv
// Directed bench for weight_update_seq.
// Static x/w tables feed the reads; writes are compared per cycle.
module tb_weight_update_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] mu_error;
  logic        busy;
  logic        done;
  logic [1:0]  x_rd_addr;
  logic [15:0] x_rd_data;
  logic [1:0]  w_rd_addr;
  logic [15:0] w_rd_data;
  logic        w_wr_en;
  logic [1:0]  w_wr_addr;
  logic [15:0] w_wr_data;

  logic [15:0] x_mem [4];
  logic [15:0] w_mem [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign x_rd_data = x_mem[x_rd_addr];
  assign w_rd_data = w_mem[w_rd_addr];

  weight_update_seq #(
    .WIDTH(16), .QP(12), .NTAPS(4), .AW(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mu_error (mu_error),
    .busy     (busy),
    .done     (done),
    .x_rd_addr(x_rd_addr),
    .x_rd_data(x_rd_data),
    .w_rd_addr(w_rd_addr),
    .w_rd_data(w_rd_data),
    .w_wr_en  (w_wr_en),
    .w_wr_addr(w_wr_addr),
    .w_wr_data(w_wr_data)
  );

  task automatic load(input logic [3:0][15:0] xs,
                      input logic [3:0][15:0] ws);
    for (int i = 0; i < 4; i++) begin
      x_mem[i] = xs[i];
      w_mem[i] = ws[i];
    end
  endtask

  // Called at a negedge with the DUT idle; optionally pokes a
  // second start (mu 0x0400) during cycle T+3.
  task automatic sweep(input string tag, input logic [15:0] mu,
                       input logic [3:0][15:0] exp,
                       input bit inject);
    mu_error = mu;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mu_error = 16'hDEAD;
    checks++;
    if (busy !== 1'b1 || w_wr_en !== 1'b0 || x_rd_addr !== 2'd0) begin
      errors++;
      $display("FAIL %s first: busy=%b wr=%b ra=%0d need 1 0 0",
               tag, busy, w_wr_en, x_rd_addr);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (w_wr_en !== 1'b1 || w_wr_addr !== 2'(k) ||
          w_wr_data !== exp[k] || busy !== 1'b1 ||
          done !== (k == 3)) begin
        errors++;
        $display("FAIL %s wr%0d: en=%b a=%0d d=%h busy=%b done=%b need 1 %0d %h 1 %b",
                 tag, k, w_wr_en, w_wr_addr, w_wr_data, busy, done,
                 k, exp[k], k == 3);
      end
      if (k < 3) begin
        checks++;
        if (x_rd_addr !== 2'(k + 1) || w_rd_addr !== 2'(k + 1)) begin
          errors++;
          $display("FAIL %s rd%0d: x=%0d w=%0d need %0d",
                   tag, k + 1, x_rd_addr, w_rd_addr, k + 1);
        end
      end
      if (inject && k == 1) begin
        start = 1'b1;
        mu_error = 16'h0400;
      end
      if (inject && k == 2) start = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || w_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL %s end: busy=%b done=%b wr=%b need 0 0 0",
               tag, busy, done, w_wr_en);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    mu_error = 16'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || w_wr_en !== 1'b0 ||
        x_rd_addr !== 2'd0 || w_rd_addr !== 2'd0 ||
        w_wr_addr !== 2'd0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b wr=%b ra=%0d wa=%0d need all 0",
               busy, done, w_wr_en, x_rd_addr, w_wr_addr);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || w_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b wr=%b need 0 0", busy, w_wr_en);
    end
  endtask

  task automatic test_basic();
    load({16'h0000, 16'hF000, 16'h0800, 16'h1000},
         {16'h0100, 16'h0100, 16'h0100, 16'h0100});
    sweep("basic", 16'h0800,
          {16'h0100, 16'hF900, 16'h0500, 16'h0900}, 1'b0);
  endtask

  task automatic test_rounding();
    load({4{16'h0001}}, {4{16'h0000}});
    sweep("round_up", 16'h0800, {4{16'h0001}}, 1'b0);
    sweep("round_dn", 16'h07FF, {4{16'h0000}}, 1'b0);
  endtask

  task automatic test_wrap();
    load({4{16'h1000}}, {4{16'h7FFF}});
    sweep("wrap", 16'h1000, {4{16'h8FFF}}, 1'b0);
  endtask

  task automatic test_start_busy();
    load({16'h0000, 16'hF000, 16'h0800, 16'h1000},
         {4{16'h0100}});
    sweep("busy_start", 16'h0800,
          {16'h0100, 16'hF900, 16'h0500, 16'h0900}, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || w_wr_en !== 1'b0) begin
        errors++;
        $display("FAIL busy_start_q%0d: busy=%b done=%b wr=%b need 0 0 0",
                 i, busy, done, w_wr_en);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0][15:0] exp;
    exp = {16'h0100, 16'hF900, 16'h0500, 16'h0900};
    load({16'h0000, 16'hF000, 16'h0800, 16'h1000},
         {4{16'h0100}});
    mu_error = 16'h0800;
    start = 1'b1;
    for (int r = 0; r < 12; r++) begin
      int m;
      @(negedge clk);
      m = r % 6;
      checks++;
      if (busy !== (m != 5) || done !== (m == 4) ||
          w_wr_en !== (m >= 1 && m <= 4)) begin
        errors++;
        $display("FAIL b2b_ctl r%0d: busy=%b done=%b wr=%b need %b %b %b",
                 r, busy, done, w_wr_en, m != 5, m == 4,
                 m >= 1 && m <= 4);
      end
      if (m >= 1 && m <= 4) begin
        checks++;
        if (w_wr_addr !== 2'(m - 1) || w_wr_data !== exp[m-1]) begin
          errors++;
          $display("FAIL b2b_wr r%0d: a=%0d d=%h need %0d %h",
                   r, w_wr_addr, w_wr_data, m - 1, exp[m-1]);
        end
      end
      if (m <= 3) begin
        checks++;
        if (x_rd_addr !== 2'(m)) begin
          errors++;
          $display("FAIL b2b_rd r%0d: ra=%0d need %0d", r, x_rd_addr, m);
        end
      end
      if (r == 11) start = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop: busy=%b need 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    load({16'h0000, 16'hF000, 16'h0800, 16'h1000},
         {4{16'h0100}});
    mu_error = 16'h0800;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || w_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: busy=%b done=%b wr=%b need 0 0 0",
               busy, done, w_wr_en);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || w_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_idle: busy=%b done=%b wr=%b need 0 0 0",
               busy, done, w_wr_en);
    end
    sweep("rst_resume", 16'h0800,
          {16'h0100, 16'hF900, 16'h0500, 16'h0900}, 1'b0);
  endtask

  initial begin
    load({4{16'h0000}}, {4{16'h0000}});
    test_reset();
    test_basic();
    test_rounding();
    test_wrap();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
